// File: rtl/map_scroll_renderer.sv
// Scaled, frame-synchronous scrolling background renderer for the VGA path.
// Optional palette color key: define COLOR_KEY_EN (adds KEY_INDEX / KEY_RGB).
module map_scroll_renderer #(
  parameter int SCR_W       = 640,
  parameter int SCR_H       = 480,
  parameter int SRC_W       = 200,
  parameter int SRC_H       = 200,
  parameter int NUM_MAPS    = 4,
  parameter int IDX_W       = 5,
  parameter int ROM_LAT     = 1,
  parameter int SCROLL_STEP = 4,
  parameter int INIT_MAP    = 0,
`ifdef COLOR_KEY_EN
  parameter logic [IDX_W-1:0] KEY_INDEX = '0,
  parameter logic [11:0]      KEY_RGB   = 12'h000,
`endif
  localparam int MAP_W  = (NUM_MAPS > 1) ? $clog2(NUM_MAPS) : 1,
  localparam int ADDR_W = $clog2(NUM_MAPS * SRC_W * SRC_H)
) (
  input  logic              vga_clk,
  input  logic              reset_n,
  input  logic [9:0]        DrawX,
  input  logic [9:0]        DrawY,
  input  logic              blank,
  input  logic              scroll_req,
  input  logic [1:0]        scroll_dir,
  input  logic [MAP_W-1:0]  target_map,
  output logic              busy,
  output logic              done,
  output logic [MAP_W-1:0]  cur_map,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pal_idx,
  input  logic [11:0]       pal_rgb,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue
);

  localparam int OFF_W = $clog2(((SRC_W > SRC_H) ? SRC_W : SRC_H) + 1);
  localparam logic [OFF_W-1:0] LIM_W = OFF_W'(SRC_W);
  localparam logic [OFF_W-1:0] LIM_H = OFF_W'(SRC_H);

  typedef enum logic {IDLE, SCROLL} state_t;

  state_t            state, state_nx;
  logic [OFF_W-1:0]  offset, offset_nx, off_inc;
  logic [MAP_W-1:0]  tgt, tgt_nx, cur_nx;
  logic [1:0]        dir, dir_nx;
  logic              xy0_q, xy0, frame_start;
  logic [ROM_LAT:0]  vld_pipe;
  logic [ADDR_W-1:0] addr_nx;
  logic [11:0]       rgb_nx;
  int unsigned       sx, sy, v, mx, my, mm, off;

  assign xy0         = (DrawX == '0) && (DrawY == '0);
  assign frame_start = xy0 && !xy0_q;
  assign busy        = (state == SCROLL);
  assign pal_idx     = rom_q;
  assign off_inc     = offset + OFF_W'(SCROLL_STEP);

  always_comb begin
    state_nx  = state;
    offset_nx = offset;
    tgt_nx    = tgt;
    dir_nx    = dir;
    cur_nx    = cur_map;
    done      = 1'b0;
    case (state)
      IDLE: if (scroll_req && target_map != cur_map && 32'(target_map) < NUM_MAPS) begin
        state_nx  = SCROLL;
        tgt_nx    = target_map;
        dir_nx    = scroll_dir;
        offset_nx = '0;
      end
      SCROLL: if (frame_start) begin
        // offset only moves at frame start so a whole frame sees one offset
        if (off_inc == (dir[1] ? LIM_H : LIM_W)) begin
          cur_nx    = tgt;
          offset_nx = '0;
          done      = 1'b1;
          state_nx  = IDLE;
        end else begin
          offset_nx = off_inc;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  // Screen -> texel scaling, then select current/target map by scroll window.
  always_comb begin
    sx = (32'(DrawX) * SRC_W) / SCR_W;
    sy = (32'(DrawY) * SRC_H) / SCR_H;
    if (sx > SRC_W - 1) sx = SRC_W - 1;
    if (sy > SRC_H - 1) sy = SRC_H - 1;
    off = 32'(offset);
    mm  = 32'(cur_map);
    mx  = sx;
    my  = sy;
    v   = 0;
    case (dir)
      2'd0: begin
        v = sx + off;
        if (v >= SRC_W) begin mm = 32'(tgt); mx = v - SRC_W; end
        else mx = v;
      end
      2'd1: begin
        v = sx + SRC_W - off;
        if (v >= SRC_W) mx = v - SRC_W;
        else begin mm = 32'(tgt); mx = v; end
      end
      2'd2: begin
        v = sy + off;
        if (v >= SRC_H) begin mm = 32'(tgt); my = v - SRC_H; end
        else my = v;
      end
      default: begin
        v = sy + SRC_H - off;
        if (v >= SRC_H) my = v - SRC_H;
        else begin mm = 32'(tgt); my = v; end
      end
    endcase
    addr_nx = ADDR_W'(mm * SRC_W * SRC_H + my * SRC_W + mx);
  end

  always_comb begin
    rgb_nx = '0;
    if (vld_pipe[ROM_LAT]) begin
      rgb_nx = pal_rgb;
`ifdef COLOR_KEY_EN
      if (rom_q == KEY_INDEX) rgb_nx = KEY_RGB;
`endif
    end
  end

  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      offset   <= '0;
      tgt      <= '0;
      dir      <= '0;
      cur_map  <= MAP_W'(INIT_MAP);
      xy0_q    <= 1'b0;
      rom_addr <= '0;
      vld_pipe <= '0;
      red      <= '0;
      green    <= '0;
      blue     <= '0;
    end else begin
      state    <= state_nx;
      offset   <= offset_nx;
      tgt      <= tgt_nx;
      dir      <= dir_nx;
      cur_map  <= cur_nx;
      xy0_q    <= xy0;
      rom_addr <= addr_nx;
      vld_pipe <= {vld_pipe[ROM_LAT-1:0], blank};
      red      <= rgb_nx[11:8];
      green    <= rgb_nx[7:4];
      blue     <= rgb_nx[3:0];
    end
  end

endmodule

// File: tb/tb_map_scroll_renderer.sv
// Bench for map_scroll_renderer: constant vector table, randomized pixel streams
// against an arithmetic map-strip model, and hand sequences for scroll/reset/key.
module tb_map_scroll_renderer;
  localparam int SCR_W = 640, SCR_H = 480, SRC_W = 200, SRC_H = 200;
  localparam int NUM_MAPS = 4, IDX_W = 5, STEP = 4, ADDR_W = 18;

  logic              vga_clk = 1'b0, reset_n = 1'b0;
  logic [9:0]        DrawX = '0, DrawY = '0;
  logic              blank = 1'b0, scroll_req = 1'b0;
  logic [1:0]        scroll_dir = '0, target_map = '0;
  logic              busy, done;
  logic [1:0]        cur_map;
  logic [ADDR_W-1:0] rom_addr;
  logic [IDX_W-1:0]  rom_q = '0, pal_idx;
  logic [11:0]       pal_rgb;
  logic [3:0]        red, green, blue;
  logic              rom_force = 1'b0;
  logic [IDX_W-1:0]  rom_force_val = '0;

  int n_cmp = 0, n_bad = 0, n_done = 0;
  int m_cur = 0, m_tgt = 0, m_dir = 0, m_off = 0;
  bit m_busy = 0;

  typedef struct { int dx; int dy; bit bl; } pix_t;
  typedef struct { int dx; int dy; bit bl; int unsigned ea; } vec_t;
  pix_t pq[$];
  vec_t tbl[11];

  always #5 vga_clk = ~vga_clk;

  map_scroll_renderer #(
    .SCR_W(SCR_W), .SCR_H(SCR_H), .SRC_W(SRC_W), .SRC_H(SRC_H),
    .NUM_MAPS(NUM_MAPS), .IDX_W(IDX_W), .ROM_LAT(1), .SCROLL_STEP(STEP),
`ifdef COLOR_KEY_EN
    .KEY_INDEX(5'd0), .KEY_RGB(12'hF0F),
`endif
    .INIT_MAP(0)
  ) dut (
    .vga_clk(vga_clk), .reset_n(reset_n), .DrawX(DrawX), .DrawY(DrawY),
    .blank(blank), .scroll_req(scroll_req), .scroll_dir(scroll_dir),
    .target_map(target_map), .busy(busy), .done(done), .cur_map(cur_map),
    .rom_addr(rom_addr), .rom_q(rom_q), .pal_idx(pal_idx), .pal_rgb(pal_rgb),
    .red(red), .green(green), .blue(blue)
  );

  function automatic logic [IDX_W-1:0] rom_fn(int unsigned a);
    return IDX_W'((a * 32'd7 + (a >> 6)) ^ (a >> 3));
  endfunction

  function automatic logic [11:0] pal_fn(logic [IDX_W-1:0] i);
    return 12'(32'(i) * 137 + 709);
  endfunction

  function automatic logic [11:0] exp_rgb(logic [IDX_W-1:0] i, bit bl);
    if (!bl) return 12'h000;
`ifdef COLOR_KEY_EN
    if (i == 0) return 12'hF0F;
`endif
    return pal_fn(i);
  endfunction

  always @(posedge vga_clk) rom_q <= rom_force ? rom_force_val : rom_fn(32'(rom_addr));
  assign pal_rgb = pal_fn(pal_idx);

  // Two maps laid side by side (or stacked) form a strip; the screen is a
  // window into it whose start moves by the scroll offset.
  function automatic int unsigned model_addr(int dx, int dy);
    int sx = dx * SRC_W / SCR_W;
    int sy = dy * SRC_H / SCR_H;
    int map, x, y, p;
    if (sx > SRC_W - 1) sx = SRC_W - 1;
    if (sy > SRC_H - 1) sy = SRC_H - 1;
    map = m_cur; x = sx; y = sy;
    case (m_dir)
      0: begin p = sx + m_off;         if (p >= SRC_W) map = m_tgt; x = p % SRC_W; end
      1: begin p = sx + SRC_W - m_off; if (p <  SRC_W) map = m_tgt; x = p % SRC_W; end
      2: begin p = sy + m_off;         if (p >= SRC_H) map = m_tgt; y = p % SRC_H; end
      default: begin p = sy + SRC_H - m_off; if (p < SRC_H) map = m_tgt; y = p % SRC_H; end
    endcase
    return map * SRC_W * SRC_H + y * SRC_W + x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic rand_pix(input int k);
    pix_t p;
    for (int i = 0; i < k; i++) begin
      p.dx = $urandom_range(0, 799);
      p.dy = $urandom_range(0, 524);
      p.bl = 1'($urandom_range(0, 3) != 0);
      if (p.dx == 0 && p.dy == 0) p.dx = 1;
      pq.push_back(p);
    end
  endtask

  // Back-to-back pixels: address one cycle after sampling, colour three.
  task automatic run_stream(input string tag);
    int unsigned ea[$];
    logic [11:0] er[$];
    int nn = pq.size();
    for (int n = 0; n < nn + 3; n++) begin
      @(posedge vga_clk); #1;
      if (n < nn) begin
        DrawX = 10'(pq[n].dx); DrawY = 10'(pq[n].dy); blank = pq[n].bl;
        ea.push_back(model_addr(pq[n].dx, pq[n].dy));
        er.push_back(exp_rgb(rom_fn(ea[n]), pq[n].bl));
      end else begin
        DrawX = 10'd1; DrawY = 10'd1; blank = 1'b0;
      end
      @(negedge vga_clk);
      if (n >= 1 && n - 1 < nn) chk({tag, " addr"}, 32'(rom_addr), ea[n-1]);
      if (n >= 3) chk({tag, " rgb"}, 32'({red, green, blue}), 32'(er[n-3]));
    end
    pq.delete();
  endtask

  task automatic request(input int d, input int t);
    @(posedge vga_clk); #1;
    scroll_req = 1'b1; scroll_dir = 2'(d); target_map = 2'(t); DrawX = 10'd1; DrawY = 10'd1;
    if (!m_busy && t != m_cur && t < NUM_MAPS) begin
      m_busy = 1; m_tgt = t; m_dir = d; m_off = 0;
    end
    @(posedge vga_clk); #1;
    scroll_req = 1'b0;
    @(negedge vga_clk);
    chk("req busy", 32'(busy), 32'(m_busy));
    chk("req cur_map", 32'(cur_map), 32'(m_cur));
    chk("req done", 32'(done), 0);
  endtask

  task automatic frame_start(input bit req, input int rt);
    bit exp_done = 0;
    @(posedge vga_clk); #1;
    DrawX = '0; DrawY = '0; blank = 1'b1; scroll_req = req; target_map = 2'(rt);
    if (m_busy) begin
      m_off += STEP;
      if (m_off == ((m_dir >= 2) ? SRC_H : SRC_W)) begin
        exp_done = 1; m_cur = m_tgt; m_off = 0; m_busy = 0;
      end
    end
    @(negedge vga_clk);
    chk("frame done", 32'(done), 32'(exp_done));
    n_done += int'(done);
    @(posedge vga_clk); #1;
    DrawX = 10'd1; scroll_req = 1'b0;
  endtask

  task automatic full_scroll(input int d, input int t, input int s1, input int s2);
    request(d, t);
    for (int f = 1; f <= 50; f++) begin
      frame_start(0, 0);
      if (f == s1 || f == s2) begin rand_pix(25); run_stream("scroll"); end
    end
    @(negedge vga_clk);
    chk("scroll end busy", 32'(busy), 0);
    chk("scroll end cur_map", 32'(cur_map), 32'(t));
  endtask

  initial begin
    #2000000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{320, 240, 1, 20100};
    tbl[1]  = '{320, 240, 0, 20100};
    tbl[2]  = '{0,   0,   1, 0};
    tbl[3]  = '{639, 479, 1, 39999};
    tbl[4]  = '{4,   3,   1, 201};
    tbl[5]  = '{3,   2,   1, 0};
    tbl[6]  = '{700, 500, 1, 39999};
    tbl[7]  = '{1023, 1023, 0, 39999};
    tbl[8]  = '{639, 0,   1, 199};
    tbl[9]  = '{0,   479, 1, 39800};
    tbl[10] = '{160, 120, 1, 10050};

    // reset held while inputs toggle
    for (int i = 0; i < 5; i++) begin
      @(posedge vga_clk); #1;
      DrawX = 10'($urandom_range(0, 639)); DrawY = 10'($urandom_range(0, 479)); blank = 1'b1;
      @(negedge vga_clk);
      chk("rst rgb", 32'({red, green, blue}), 0);
      chk("rst busy", 32'(busy), 0);
      chk("rst done", 32'(done), 0);
      chk("rst cur_map", 32'(cur_map), 0);
    end
    @(posedge vga_clk); #1;
    reset_n = 1'b1; DrawX = 10'd1; DrawY = 10'd1;

    foreach (tbl[i]) begin
      @(posedge vga_clk); #1;
      DrawX = 10'(tbl[i].dx); DrawY = 10'(tbl[i].dy); blank = tbl[i].bl;
      @(posedge vga_clk); @(negedge vga_clk);
      chk("tbl addr", 32'(rom_addr), tbl[i].ea);
      @(posedge vga_clk); @(posedge vga_clk); @(negedge vga_clk);
      chk("tbl rgb", 32'({red, green, blue}), 32'(exp_rgb(rom_fn(tbl[i].ea), tbl[i].bl)));
    end

    rand_pix(40); run_stream("idle");
    request(0, 0);

    // right scroll 0 -> 1, with ignored requests while busy and at done
    n_done = 0;
    request(0, 1);
    frame_start(0, 0);
    @(posedge vga_clk); #1;
    DrawX = 10'd636; DrawY = 10'd0; blank = 1'b1;
    @(posedge vga_clk); @(negedge vga_clk);
    chk("right off4 addr", 32'(rom_addr), 40002);
    rand_pix(30); run_stream("right");
    request(2, 3);
    for (int f = 2; f <= 49; f++) begin
      frame_start(0, 0);
      if (f == 25) begin rand_pix(30); run_stream("right mid"); end
    end
    frame_start(1, 3);
    @(negedge vga_clk);
    chk("right done count", 32'(n_done), 1);
    chk("right busy", 32'(busy), 0);
    chk("right cur_map", 32'(cur_map), 1);
    chk("right done low", 32'(done), 0);
    rand_pix(20); run_stream("idle map1");

    full_scroll(2, 2, 13, 37);
    full_scroll(3, 0, 9, 44);
    full_scroll(0, 3, 20, 20);
    full_scroll(1, 1, 1, 50);

    // left scroll abandoned by reset at offset 100
    request(1, 2);
    for (int f = 1; f <= 25; f++) frame_start(0, 0);
    rand_pix(30); run_stream("left off100");
    @(posedge vga_clk); #1;
    reset_n = 1'b0;
    m_cur = 0; m_busy = 0; m_off = 0;
    for (int i = 0; i < 3; i++) begin
      @(negedge vga_clk);
      chk("midrst busy", 32'(busy), 0);
      chk("midrst cur_map", 32'(cur_map), 0);
      chk("midrst rgb", 32'({red, green, blue}), 0);
      @(posedge vga_clk); #1;
    end
    reset_n = 1'b1;
    DrawX = '0; DrawY = '0; blank = 1'b1;
    @(posedge vga_clk); @(negedge vga_clk);
    chk("post rst addr", 32'(rom_addr), 0);
    chk("post rst done", 32'(done), 0);
    rand_pix(30); run_stream("post rst");

    // key index / plain palette path with a forced ROM value
    for (int k = 0; k < 2; k++) begin
      rom_force = 1'b1; rom_force_val = (k == 0) ? 5'd0 : 5'd3;
      @(posedge vga_clk); #1;
      DrawX = 10'd5; DrawY = 10'd5; blank = 1'b1;
      @(posedge vga_clk); @(posedge vga_clk); @(posedge vga_clk); @(negedge vga_clk);
      chk("key rgb", 32'({red, green, blue}), 32'(exp_rgb(rom_force_val, 1'b1)));
    end
    rom_force = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
